seq_chunk_alu: RTL and testbench

- Multi-cycle, width-parametrised integer ALU for the PipeCPU datapath. It is the successor of the 32-bit combinational ripple-carry ALU.
- Computes AND, OR, ADD, SUB and signed SLT. The carry chain is evaluated CHUNK bits per clock, which bounds the critical path at wide WIDTH.
- Uses a start/busy/done handshake and adds zero, overflow and carry-out flags.
- SLT is sign-correct: set = sum MSB XOR overflow, not the raw sum MSB.

---
 rtl/seq_chunk_alu_pkg.sv | 19 +
 rtl/seq_chunk_alu_chunk.sv | 36 +++
 rtl/seq_chunk_alu.sv | 158 +++++++++++++++
 tb/tb_seq_chunk_alu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_alu_pkg.sv
// Shared opcodes, FSM states and opcode helpers for the chunked sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // SUB and SLT both run the adder as A + ~B + 1.
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/seq_chunk_alu_chunk.sv
// One CHUNK-wide slice: bitwise AND/OR plus a ripple adder with optional B inversion.
module alu_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    input  logic             cin,
    output logic [CHUNK-1:0] and_o,
    output logic [CHUNK-1:0] or_o,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   c;

    always_comb begin
        bx    = b ^ {CHUNK{bin}};
        c     = '0;
        sum_o = '0;
        c[0]  = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign and_o    = a & b;
    assign or_o     = a | b;
    assign cout     = c[CHUNK];
    // Carry into the slice's top bit; on the last chunk this feeds signed overflow.
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_alu.sv
// Multi-cycle ALU: one CHUNK-wide slice reused NCHUNK times, start/busy/done handshake.
module seq_chunk_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_alu: CHUNK must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic [CHUNK-1:0] ch_a, ch_b, ch_and, ch_or, ch_sum, ch_res;
    logic             ch_cout, ch_cmsb;

    assign ch_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign ch_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a       (ch_a),
        .b       (ch_b),
        .bin     (op_is_sub(op_q)),
        .cin     (carry_q),
        .and_o   (ch_and),
        .or_o    (ch_or),
        .sum_o   (ch_sum),
        .cout    (ch_cout),
        .c_msb_in(ch_cmsb)
    );

    always_comb begin
        case (op_q)
            OP_AND:  ch_res = ch_and;
            OP_OR:   ch_res = ch_or;
            default: ch_res = ch_sum;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                a_d     = dataA;
                b_d     = dataB;
                op_d    = op;
                idx_d   = '0;
                carry_d = op_is_sub(op);
            end
        end else begin
            acc_d[int'(idx_q)*CHUNK +: CHUNK] = ch_res;
            carry_d = ch_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
                ovf_d   = ch_cmsb ^ ch_cout;
                cout_d  = 1'b0;
                case (op_q)
                    OP_AND, OP_OR: begin
                        result_d = acc_d;
                        ovf_d    = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        result_d = acc_d;
                        cout_d   = ch_cout;
                    end
                    // Signed less-than: sum sign corrected by overflow.
                    OP_SLT:  result_d = WIDTH'(acc_d[WIDTH-1] ^ ovf_d);
                    default: begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                    end
                endcase
                zero_d = (result_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign cout     = cout_q;

endmodule

// File: tb/tb_seq_chunk_alu.sv
// Self-checking bench for seq_chunk_alu (defaults WIDTH=32, CHUNK=8).
module tb_seq_chunk_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] dataA = '0, dataB = '0;
    logic        busy, done, zero, overflow, cout;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    seq_chunk_alu #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .result(result), .zero(zero), .overflow(overflow), .cout(cout)
    );

    always #5 clk = ~clk;

    // Reference: ALU semantics from plain integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic v, output logic c);
        logic [32:0] s;
        logic [31:0] d;
        r = '0; v = 1'b0; c = 1'b0;
        d = a - b;
        case (o)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                r = d;
                c = (a >= b);
                v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            3'b111: begin
                r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            default: r = '0;
        endcase
        z = (r == 32'd0);
    endfunction

    // Drives one request from the current cycle (cycle 0); returns in the done cycle
    // with cyc = cycle number of done, busy_ok = busy high in 1..cyc-1 and low at done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic busy_ok);
        op = o; dataA = a; dataB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, zero, overflow, cout} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h z=%b v=%b c=%b, want all 0",
                     busy, done, result, zero, overflow, cout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [9] = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] t_a  [9] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'h80000000, 32'd1,
                                  32'hF0F0F0F0, 32'hF0F0F0F0, 32'd5, 32'hFFFFFFFF};
        logic [31:0] t_b  [9] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h80000000,
                                  32'hFF00FF00, 32'hFF00FF00, 32'd5, 32'd1};
        logic [31:0] t_r  [9] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0,
                                  32'hF000F000, 32'hFFF0FFF0, 32'd0, 32'd0};
        logic [2:0]  t_zvc[9] = '{3'b010, 3'b101, 3'b000, 3'b010, 3'b110,
                                  3'b000, 3'b000, 3'b100, 3'b101};
        int cyc;
        logic bok;
        for (int i = 0; i < 9; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], cyc, bok);
            n_cmp++;
            if (cyc !== 5 || bok !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_latency: done cycle %0d busy_ok=%b, want 5/1", i, cyc, bok);
            end
            n_cmp++;
            if (result !== t_r[i] || {zero, overflow, cout} !== t_zvc[i]) begin
                n_err++;
                $display("FAIL dir%0d_value: got %h zvc=%b, want %h zvc=%b",
                         i, result, {zero, overflow, cout}, t_r[i], t_zvc[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || result !== t_r[i]) begin
                n_err++;
                $display("FAIL dir%0d_hold: done=%b result=%h, want 0/%h", i, done, result, t_r[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  codes [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        logic [31:0] corners [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
        logic [31:0] a, b, er;
        logic [2:0]  o;
        logic ez, ev, ec, bok;
        int cyc;
        for (int i = 0; i < 60; i++) begin
            o = codes[($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)];
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            model(o, a, b, er, ez, ev, ec);
            run_op(o, a, b, cyc, bok);
            n_cmp++;
            if (cyc !== 5 || bok !== 1'b1 || result !== er || {zero, overflow, cout} !== {ez, ev, ec}) begin
                n_err++;
                $display("FAIL rand%0d op=%b a=%h b=%h: got cyc=%0d bok=%b %h zvc=%b, want 5/1 %h zvc=%b",
                         i, o, a, b, cyc, bok, result, {zero, overflow, cout}, er, {ez, ev, ec});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int cyc;
        op = 3'b010; dataA = 32'd10; dataB = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 2 || cyc == 3) begin
                start = 1'b1; op = 3'b110; dataA = $urandom; dataB = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (cyc !== 5 || result !== 32'd30 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore: cyc=%0d result=%h c=%b, want 5/%h/0", cyc, result, cout, 32'd30);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_idle: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic bok;
        run_op(3'b001, 32'h0000_00F0, 32'h0000_000F, cyc, bok);
        n_cmp++;
        if (cyc !== 5 || result !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL b2b_first: cyc=%0d result=%h, want 5/%h", cyc, result, 32'hFF);
        end
        run_op(3'b010, 32'd100, 32'd23, cyc, bok);
        n_cmp++;
        if (cyc !== 5 || bok !== 1'b1 || result !== 32'd123) begin
            n_err++;
            $display("FAIL b2b_second: cyc=%0d bok=%b result=%h, want 5/1/%h", cyc, bok, result, 32'd123);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, seen;
        logic bok;
        op = 3'b010; dataA = 32'h1234; dataB = 32'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || {zero, overflow, cout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_async: busy=%b done=%b result=%h zvc=%b, want 0/0/0/000",
                     busy, done, result, {zero, overflow, cout});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/busy set, want 0", seen);
        end
        run_op(3'b010, 32'd3, 32'd4, cyc, bok);
        n_cmp++;
        if (cyc !== 5 || result !== 32'd7 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_next: cyc=%0d result=%h, want 5/%h", cyc, result, 32'd7);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
